// File: rtl/note_pkg.sv
// Note codes and field geometry shared by the chart reader, the scroller and the LCD driver.
// The two code bits map straight onto the LCD driver's cell codes.
package note_pkg;

    typedef enum logic [1:0] {
        NOTE_NONE       = 2'd0,
        NOTE_TAP        = 2'd1,
        NOTE_HOLD_START = 2'd2,
        NOTE_HOLD_MID   = 2'd3
    } note_code_t;

    localparam int LCD_COLS = 16;

    // Only taps and hold heads can be hit or missed; hold bodies are decoration.
    function automatic logic is_judgeable(input logic [1:0] code);
        return (code == NOTE_TAP) || (code == NOTE_HOLD_START);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running step divider: tick is high for the one clock where the count sits at TICK_DIV-1.
// The count only advances while enable is high, so a pause resumes mid-period.
module tick_divider #(
    parameter int TICK_DIV = 2_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int              CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = enable && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/note_scroller.sv
// Two-lane note field that scrolls left one column per step, fed from a one-entry chart buffer,
// with hit/miss judgement at column 0. Bitplanes are taken directly from the field registers.
module note_scroller
    import note_pkg::*;
#(
    parameter int TICK_DIV = 2_500_000,
    parameter int COLS     = LCD_COLS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            chart_valid,
    input  logic [1:0]      chart_up,
    input  logic [1:0]      chart_down,
    output logic            chart_ready,
    input  logic            hit_up,
    input  logic            hit_down,
    output logic [COLS-1:0] noteup_bit0,
    output logic [COLS-1:0] noteup_bit1,
    output logic [COLS-1:0] notedown_bit0,
    output logic [COLS-1:0] notedown_bit1,
    output logic            step,
    output logic            hit_up_ok,
    output logic            hit_down_ok,
    output logic            miss_up,
    output logic            miss_down
);

    logic       tick;
    logic [1:0] up_field   [COLS];
    logic [1:0] down_field [COLS];
    logic       buf_full;
    logic [1:0] buf_up;
    logic [1:0] buf_down;
    logic       transfer;
    logic       up_hit_c;
    logic       down_hit_c;
    logic       up_miss_c;
    logic       down_miss_c;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    // Chart handshake: a column moves on every clock where chart_valid and chart_ready are both
    // high; ready is low exactly while the buffer holds an unconsumed column.
    assign chart_ready = !buf_full;
    assign transfer    = chart_valid && !buf_full;

    // Hits are judged against the pre-step column 0, so a hit on a step cycle cancels the miss.
    assign up_hit_c    = enable && hit_up   && is_judgeable(up_field[0]);
    assign down_hit_c  = enable && hit_down && is_judgeable(down_field[0]);
    assign up_miss_c   = tick && is_judgeable(up_field[0])   && !up_hit_c;
    assign down_miss_c = tick && is_judgeable(down_field[0]) && !down_hit_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < COLS; i++) begin
                up_field[i]   <= NOTE_NONE;
                down_field[i] <= NOTE_NONE;
            end
            buf_full    <= 1'b0;
            buf_up      <= NOTE_NONE;
            buf_down    <= NOTE_NONE;
            step        <= 1'b0;
            hit_up_ok   <= 1'b0;
            hit_down_ok <= 1'b0;
            miss_up     <= 1'b0;
            miss_down   <= 1'b0;
        end else begin
            step        <= tick;
            hit_up_ok   <= up_hit_c;
            hit_down_ok <= down_hit_c;
            miss_up     <= up_miss_c;
            miss_down   <= down_miss_c;

            if (transfer) begin
                buf_full <= 1'b1;
                buf_up   <= chart_up;
                buf_down <= chart_down;
            end else if (tick) begin
                buf_full <= 1'b0;
            end

            if (tick) begin
                for (int i = 0; i < COLS - 1; i++) begin
                    up_field[i]   <= up_field[i + 1];
                    down_field[i] <= down_field[i + 1];
                end
                // An empty buffer on a step is an underrun and scrolls in a blank column.
                up_field[COLS-1]   <= buf_full ? buf_up   : NOTE_NONE;
                down_field[COLS-1] <= buf_full ? buf_down : NOTE_NONE;
            end else begin
                if (up_hit_c) begin
                    up_field[0] <= NOTE_NONE;
                end
                if (down_hit_c) begin
                    down_field[0] <= NOTE_NONE;
                end
            end
        end
    end

    always_comb begin
        noteup_bit0   = '0;
        noteup_bit1   = '0;
        notedown_bit0 = '0;
        notedown_bit1 = '0;
        for (int i = 0; i < COLS; i++) begin
            noteup_bit0[i]   = up_field[i][0];
            noteup_bit1[i]   = up_field[i][1];
            notedown_bit0[i] = down_field[i][0];
            notedown_bit1[i] = down_field[i][1];
        end
    end

endmodule
